// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: sequencer state
// encodings and the NOP used when the IF/ID register is flushed.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERR      = 2'd3
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Value the IF/ID instruction register loads: a NOP when flushed,
    // otherwise the freshly fetched word.
    function automatic logic [31:0] ifid_load_value(input logic        flush,
                                                    input logic [31:0] fetched);
        return flush ? NOP_INSTR : fetched;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-detection inputs and pipeline-register control outputs of the
// hazard controller. The controller uses the master view, the datapath
// (or a testbench) the slave view.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipeline_hazard_ctrl_pkg::*;

    logic             start_i;
    logic [4:0]       ifid_rs1_i;
    logic [4:0]       ifid_rs2_i;
    logic             ifid_uses_rs2_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rd_i;
    logic             branch_taken_i;
    logic             mem_req_i;
    logic             mem_ack_i;

    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_hold_o;
    state_t           state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             mem_timeout_o;

    modport master (
        input  start_i, ifid_rs1_i, ifid_rs2_i, ifid_uses_rs2_i,
               idex_memread_i, idex_rd_i, branch_taken_i, mem_req_i, mem_ack_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               pipe_hold_o, state_o, stall_cnt_o, flush_cnt_o, mem_timeout_o
    );

    modport slave (
        output start_i, ifid_rs1_i, ifid_rs2_i, ifid_uses_rs2_i,
               idex_memread_i, idex_rd_i, branch_taken_i, mem_req_i, mem_ack_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
               pipe_hold_o, state_o, stall_cnt_o, flush_cnt_o, mem_timeout_o
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module hazard_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Clear wins over counting; counting stops at the maximum value.
    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (en)
            cnt <= sat_inc(cnt);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: decides each cycle whether the 5-stage pipeline
// advances, stalls, bubbles or flushes, and tracks memory-wait timeouts.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipeline_hazard_ctrl_if.master hz
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_nx;
    logic [TO_W-1:0] wait_cnt;
    logic [TO_W-1:0] wait_nx;
    logic            timeout_flag;
    logic            timeout_nx;
    logic            load_use;
    logic            stall_en;
    logic            cnt_clr;

    // Load-use: the load in ID/EX writes a register the IF/ID instruction reads.
    assign load_use = hz.idex_memread_i && (hz.idex_rd_i != 5'd0) &&
                      ((hz.idex_rd_i == hz.ifid_rs1_i) ||
                       (hz.ifid_uses_rs2_i && (hz.idex_rd_i == hz.ifid_rs2_i)));

    // State register, wait counter and sticky timeout flag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nx;
            wait_cnt     <= wait_nx;
            timeout_flag <= timeout_nx;
        end
    end

    // Next-state logic: start handshake, memory wait tracking, timeout.
    always_comb begin
        state_nx   = state;
        wait_nx    = wait_cnt;
        timeout_nx = timeout_flag;
        unique case (state)
            ST_IDLE: begin
                if (hz.start_i)
                    state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (hz.mem_req_i && !hz.mem_ack_i) begin
                    state_nx = ST_MEM_WAIT;
                    wait_nx  = TO_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (hz.mem_ack_i) begin
                    state_nx = ST_RUN;
                    wait_nx  = '0;
                end else if (wait_cnt == TO_W'(TIMEOUT)) begin
                    state_nx   = ST_ERR;
                    timeout_nx = 1'b1;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end
            ST_ERR: begin
                state_nx = ST_ERR;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Mealy output decode; memory hold beats load-use, which beats a taken branch.
    always_comb begin
        hz.pc_write_o    = 1'b1;
        hz.ifid_write_o  = 1'b1;
        hz.ifid_flush_o  = 1'b0;
        hz.idex_bubble_o = 1'b0;
        hz.pipe_hold_o   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                hz.pc_write_o    = 1'b0;
                hz.ifid_write_o  = 1'b0;
                hz.idex_bubble_o = 1'b1;
            end
            ST_RUN, ST_MEM_WAIT: begin
                if ((state == ST_RUN && hz.mem_req_i && !hz.mem_ack_i) ||
                    (state == ST_MEM_WAIT && !hz.mem_ack_i)) begin
                    hz.pc_write_o   = 1'b0;
                    hz.ifid_write_o = 1'b0;
                    hz.pipe_hold_o  = 1'b1;
                end else if (load_use) begin
                    hz.pc_write_o    = 1'b0;
                    hz.ifid_write_o  = 1'b0;
                    hz.idex_bubble_o = 1'b1;
                end else if (hz.branch_taken_i) begin
                    hz.ifid_flush_o = 1'b1;
                end
            end
            ST_ERR: begin
                hz.pc_write_o   = 1'b0;
                hz.ifid_write_o = 1'b0;
                hz.pipe_hold_o  = 1'b1;
            end
            default: begin
                hz.pc_write_o   = 1'b0;
                hz.ifid_write_o = 1'b0;
            end
        endcase
    end

    assign hz.state_o       = state;
    assign hz.mem_timeout_o = timeout_flag;

    // Stalls are only counted while the core is actually running.
    assign stall_en = !hz.pc_write_o && (state == ST_RUN || state == ST_MEM_WAIT);
    assign cnt_clr  = !rst_i;

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk_i),
        .clr (cnt_clr),
        .en  (stall_en),
        .cnt (hz.stall_cnt_o)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk_i),
        .clr (cnt_clr),
        .en  (hz.ifid_flush_o),
        .cnt (hz.flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz.master)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: 0 idle, 1 running, 2 waiting on memory, 3 error.
    int m_state;
    int m_wait;
    int m_stall;
    int m_flush;
    bit m_to;
    bit m_known = 1'b0;
    bit e_pc, e_ifw, e_fl, e_bub, e_hold;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_outputs();
        bit lu;
        bit blocked;
        lu = hz.idex_memread_i && (hz.idex_rd_i != 0) &&
             ((hz.idex_rd_i == hz.ifid_rs1_i) ||
              (hz.ifid_uses_rs2_i && hz.idex_rd_i == hz.ifid_rs2_i));
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0;
        if (m_state == 0) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
        end else if (m_state == 3) begin
            e_pc = 0; e_ifw = 0; e_hold = 1;
        end else begin
            blocked = (m_state == 1) ? (hz.mem_req_i && !hz.mem_ack_i) : !hz.mem_ack_i;
            if (blocked) begin
                e_pc = 0; e_ifw = 0; e_hold = 1;
            end else if (lu) begin
                e_pc = 0; e_ifw = 0; e_bub = 1;
            end else if (hz.branch_taken_i) begin
                e_fl = 1;
            end
        end
    endtask

    task automatic model_advance();
        if (!rst) begin
            m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_to = 0;
            m_known = 1'b1;
            return;
        end
        if (!m_known) return;
        if ((m_state == 1 || m_state == 2) && !e_pc && m_stall < CNT_MAX) m_stall++;
        if (e_fl && m_flush < CNT_MAX) m_flush++;
        case (m_state)
            0: if (hz.start_i) m_state = 1;
            1: if (hz.mem_req_i && !hz.mem_ack_i) begin m_state = 2; m_wait = 1; end
            2: begin
                if (hz.mem_ack_i) begin m_state = 1; m_wait = 0; end
                else if (m_wait == TIMEOUT) begin m_state = 3; m_to = 1; end
                else m_wait++;
            end
            default: m_state = 3;
        endcase
    endtask

    // One clock cycle: inputs are already set; check outputs, take the edge.
    task automatic tick();
        #1;
        model_outputs();
        if (m_known) begin
            check_eq("pc_write",    32'(hz.pc_write_o),    32'(e_pc));
            check_eq("ifid_write",  32'(hz.ifid_write_o),  32'(e_ifw));
            check_eq("ifid_flush",  32'(hz.ifid_flush_o),  32'(e_fl));
            check_eq("idex_bubble", 32'(hz.idex_bubble_o), 32'(e_bub));
            check_eq("pipe_hold",   32'(hz.pipe_hold_o),   32'(e_hold));
            check_eq("state",       32'(hz.state_o),       32'(m_state));
            check_eq("stall_cnt",   32'(hz.stall_cnt_o),   32'(m_stall));
            check_eq("flush_cnt",   32'(hz.flush_cnt_o),   32'(m_flush));
            check_eq("mem_timeout", 32'(hz.mem_timeout_o), 32'(m_to));
        end
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        hz.start_i = 0; hz.ifid_rs1_i = 0; hz.ifid_rs2_i = 0; hz.ifid_uses_rs2_i = 0;
        hz.idex_memread_i = 0; hz.idex_rd_i = 0; hz.branch_taken_i = 0;
        hz.mem_req_i = 0; hz.mem_ack_i = 0;
    endtask

    task automatic reset_and_start();
        clear_inputs();
        rst = 0; tick(); tick();
        rst = 1; hz.start_i = 1; tick();
        hz.start_i = 0;
    endtask

    initial begin
        clear_inputs();

        // Reset then idle
        rst = 0; tick(); tick();
        rst = 1;
        for (int i = 0; i < 5; i++) tick();
        #1;
        check_eq("idle_state", 32'(hz.state_o), 32'd0);
        check_eq("idle_pc_write", 32'(hz.pc_write_o), 32'd0);
        check_eq("idle_bubble", 32'(hz.idex_bubble_o), 32'd1);
        check_eq("idle_stall_cnt", 32'(hz.stall_cnt_o), 32'd0);
        check_eq("idle_flush_cnt", 32'(hz.flush_cnt_o), 32'd0);
        hz.start_i = 1; tick(); hz.start_i = 0;
        check_eq("start_to_run", 32'(hz.state_o), 32'd1);

        // Load-use on rs2
        hz.idex_memread_i = 1; hz.idex_rd_i = 5; hz.ifid_rs2_i = 5; hz.ifid_uses_rs2_i = 1;
        #1;
        check_eq("lu_pc_write", 32'(hz.pc_write_o), 32'd0);
        check_eq("lu_ifid_write", 32'(hz.ifid_write_o), 32'd0);
        check_eq("lu_bubble", 32'(hz.idex_bubble_o), 32'd1);
        tick();
        check_eq("lu_stall_cnt", 32'(hz.stall_cnt_o), 32'd1);
        hz.idex_rd_i = 0; hz.ifid_rs2_i = 0;
        #1;
        check_eq("lu_x0_pc_write", 32'(hz.pc_write_o), 32'd1);
        tick();
        check_eq("lu_x0_stall_cnt", 32'(hz.stall_cnt_o), 32'd1);

        // Branch deferred by a load-use on rs1
        hz.idex_rd_i = 7; hz.ifid_rs1_i = 7; hz.ifid_uses_rs2_i = 0; hz.branch_taken_i = 1;
        #1;
        check_eq("br_lu_flush", 32'(hz.ifid_flush_o), 32'd0);
        tick();
        hz.idex_memread_i = 0;
        #1;
        check_eq("br_flush", 32'(hz.ifid_flush_o), 32'd1);
        tick();
        check_eq("br_flush_cnt", 32'(hz.flush_cnt_o), 32'd1);

        // Memory wait of three hold cycles then ack
        reset_and_start();
        hz.mem_req_i = 1; hz.mem_ack_i = 0;
        tick(); check_eq("mw_state_1", 32'(hz.state_o), 32'd2);
        tick(); check_eq("mw_state_2", 32'(hz.state_o), 32'd2);
        tick(); check_eq("mw_state_3", 32'(hz.state_o), 32'd2);
        hz.mem_ack_i = 1;
        #1;
        check_eq("mw_ack_hold", 32'(hz.pipe_hold_o), 32'd0);
        tick();
        check_eq("mw_back_run", 32'(hz.state_o), 32'd1);
        check_eq("mw_stall_cnt", 32'(hz.stall_cnt_o), 32'd3);
        clear_inputs();

        // Timeout into ERR, survives ack, cleared by reset
        reset_and_start();
        hz.mem_req_i = 1; hz.mem_ack_i = 0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("to_before", 32'(hz.state_o), 32'd2);
        tick();
        check_eq("to_err_state", 32'(hz.state_o), 32'd3);
        check_eq("to_flag", 32'(hz.mem_timeout_o), 32'd1);
        hz.mem_ack_i = 1; tick();
        check_eq("to_err_sticky", 32'(hz.state_o), 32'd3);
        check_eq("to_flag_sticky", 32'(hz.mem_timeout_o), 32'd1);
        rst = 0; tick(); rst = 1;
        check_eq("to_reset_state", 32'(hz.state_o), 32'd0);
        check_eq("to_reset_flag", 32'(hz.mem_timeout_o), 32'd0);

        // Flush counter saturation
        reset_and_start();
        hz.branch_taken_i = 1;
        for (int i = 0; i < 10; i++) tick();
        check_eq("sat_flush_cnt", 32'(hz.flush_cnt_o), 32'(CNT_MAX));
        clear_inputs();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst                = ($urandom_range(0, 39) != 0);
            hz.start_i         = ($urandom_range(0, 3) == 0);
            hz.ifid_rs1_i      = 5'($urandom_range(0, 3));
            hz.ifid_rs2_i      = 5'($urandom_range(0, 3));
            hz.ifid_uses_rs2_i = 1'($urandom_range(0, 1));
            hz.idex_memread_i  = 1'($urandom_range(0, 1));
            hz.idex_rd_i       = 5'($urandom_range(0, 3));
            hz.branch_taken_i  = ($urandom_range(0, 2) == 0);
            hz.mem_req_i       = ($urandom_range(0, 2) == 0);
            hz.mem_ack_i       = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
